bnn_xnor_conv_engine: RTL and testbench
=======================================

// Module: bnn_xnor_conv_engine
// PURPOSE
//  Parametrised binary (XNOR-popcount) convolution engine for the Pi-to-FPGA vision path.
//  - Buffers one IMG_W x IMG_H byte image from a valid/ready pixel stream.
//  - Slides a runtime-loadable KxK byte kernel over a WIN_ROWS x WIN_COLS grid of windows
//    spaced STRIDE apart.
//  - Streams one score per window, in raster order, on a valid/ready result port.
//  - Sits between the UART RX/TX byte adapters; it contains no UART logic.
// PARAMETERS
//  IMG_W        28          image width, pixels
//  IMG_H        28          image height, pixels
//  K            3           kernel side; kernel holds K*K bytes
//  STRIDE       8           window origin spacing, rows and cols
//  WIN_ROWS     3           window grid rows
//  WIN_COLS     3           window grid cols; N_WIN = WIN_ROWS*WIN_COLS
//  ACC_W        $clog2(8*K*K+1)  score width (7 for K=3)
//  KERNEL_INIT  {3{8'hE3,8'h18,8'hE3}}  8*K*K-bit reset kernel; MSB byte = kernel[0]
//  THRESH       36          binarisation threshold (used only with BNN_THRESH_EN)
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      reset
//  pix_valid  in   1      pixel byte valid
//  pix_ready  out  1      engine accepts pixel (LOAD state only)
//  pix_data   in   8      pixel byte, raster order, row 0 col 0 first
//  kw_valid   in   1      kernel write strobe
//  kw_addr    in   $clog2(K*K)  kernel byte index, row-major
//  kw_data    in   8      kernel byte
//  res_valid  out  1      score valid
//  res_ready  in   1      downstream accepts score
//  res_data   out  ACC_W  window score
//  res_idx    out  $clog2(N_WIN)  window index of res_data
//  res_bit    out  1      res_data >= THRESH (BNN_THRESH_EN only)
//  frame_done out  1      one-cycle pulse after last score handshake
// BEHAVIOUR
//  - Reset: rst_n, asynchronous, active-low; clock clk.
//    - Outputs after reset: pix_ready=1, res_valid=0, res_data=0, res_idx=0, res_bit=0,
//      frame_done=0.
//    - State=LOAD; pixel counter and window counter = 0; kernel = KERNEL_INIT.
//    - Image RAM is not reset; it is overwritten on the next frame.
//  - FSM LOAD -> COMPUTE -> EMIT -> (COMPUTE | LOAD).
//  - LOAD:
//    - pix_ready=1; a pixel is stored at the pixel counter on pix_valid&pix_ready.
//    - On acceptance of pixel IMG_W*IMG_H-1: counter wraps to 0, next state COMPUTE, window 0.
//  - COMPUTE:
//    - Window w origin: row (w/WIN_COLS)*STRIDE, col (w%WIN_COLS)*STRIDE.
//    - One kernel tap per cycle, row-major, K*K cycles; RAM read is synchronous.
//    - Each tap adds popcount(~(pix ^ kern)), range 0..8.
//    - Accumulator is ACC_W wide, cleared at window start; it never overflows.
//  - EMIT:
//    - res_valid=1; res_data, res_idx and res_bit stay stable until res_ready.
//    - After the handshake: next window -> COMPUTE; after window N_WIN-1 -> LOAD and
//      pulse frame_done.
//  - Latency:
//    - First res_valid rises exactly K*K+2 clocks after the final pixel handshake
//      (11 for K=3).
//    - Each later res_valid rises K*K+2 clocks after the previous res handshake.
//    - Windows do not overlap.
//  - Backpressure: res_ready low holds the FSM in EMIT indefinitely; pix_ready stays 0.
//  - Kernel writes:
//    - Applied in LOAD or EMIT; ignored in COMPUTE so an in-flight window uses one kernel.
//    - A write in EMIT affects the next window.
//    - A write with kw_addr >= K*K is ignored.
//  - Simultaneous pix_valid and kw_valid in LOAD: both take effect.
//  - Reset mid-frame or mid-window:
//    - Returns to the reset state; partial image and pending scores are discarded.
//    - Runtime kernel writes are lost and the kernel returns to KERNEL_INIT.
//  - Elaboration check: (WIN_ROWS-1)*STRIDE+K <= IMG_H and (WIN_COLS-1)*STRIDE+K <= IMG_W;
//    a violation is a $fatal.
// CONFIGURATION
//  - BNN_THRESH_EN defined: res_bit = (res_data >= THRESH) is registered with res_data and
//    valid under res_valid.
//  - BNN_THRESH_EN undefined: res_bit is tied 0, no comparator is built, THRESH is unused.
// TESTING (defaults unless stated)
//  1 Send 784 pixels of 8'h00 with the default kernel -> 9 scores of 36, res_idx 0..8 in
//    order; frame_done pulses once; pix_ready returns to 1.
//  2 Send 784 pixels of 8'hE3 -> 9 scores of 51; first res_valid exactly 11 clocks after
//    the last pixel handshake.
//  3 In LOAD, write all 9 kernel bytes = 8'hFF, then send an image of 8'h01 -> 9 scores of
//    9. Also write kw_addr=9 -> no effect.
//  4 Hold res_ready=0 for 20 cycles at the first res_valid -> res_data/res_idx stable;
//    pix_ready=0; pix_valid ignored; all 9 scores then arrive in order.
//  5 Write the kernel during COMPUTE -> ignored, scores equal those of test 2. Assert rst_n
//    low after 3 scores -> res_valid=0 and pix_ready=1 immediately; a fresh zero image then
//    gives 36 with the default kernel.
//  6 With BNN_THRESH_EN and THRESH=40: image 8'hE3 -> res_bit=1 on all scores; image 8'h00
//    -> res_bit=0. Without the macro, res_bit=0 always.

Source files
------------

// File: rtl/bnn_xnor_conv_engine.sv
// bnn_xnor_conv_engine: buffers a byte image, scores a grid of KxK windows by XNOR-popcount.
// Define BNN_THRESH_EN to register res_bit = (score >= THRESH); otherwise res_bit is tied low.
module bnn_xnor_conv_engine #(
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int K        = 3,
    parameter int STRIDE   = 8,
    parameter int WIN_ROWS = 3,
    parameter int WIN_COLS = 3,
    parameter int ACC_W    = $clog2(8*K*K+1),
    parameter logic [8*K*K-1:0] KERNEL_INIT = {3{8'hE3, 8'h18, 8'hE3}},
    parameter int THRESH   = 36
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  pix_valid,
    output logic                                  pix_ready,
    input  logic [7:0]                            pix_data,
    input  logic                                  kw_valid,
    input  logic [$clog2(K*K)-1:0]                kw_addr,
    input  logic [7:0]                            kw_data,
    output logic                                  res_valid,
    input  logic                                  res_ready,
    output logic [ACC_W-1:0]                      res_data,
    output logic [$clog2(WIN_ROWS*WIN_COLS)-1:0]  res_idx,
    output logic                                  res_bit,
    output logic                                  frame_done
);
    localparam int N_PIX = IMG_W*IMG_H;
    localparam int N_TAP = K*K;
    localparam int N_WIN = WIN_ROWS*WIN_COLS;
    localparam int PIX_W = $clog2(N_PIX);
    localparam int CNT_W = $clog2(N_TAP+2);
    localparam int WIN_W = $clog2(N_WIN);
    localparam int KA_W  = $clog2(N_TAP);

    if ((WIN_ROWS-1)*STRIDE+K > IMG_H || (WIN_COLS-1)*STRIDE+K > IMG_W ||
        THRESH < 0 || THRESH > 8*N_TAP) begin : g_geom_check
        $fatal(1, "bnn_xnor_conv_engine: window grid or threshold out of range");
    end

    typedef enum logic [1:0] {LOAD, COMPUTE, EMIT} state_t;

    state_t             state;
    logic [7:0]         ram [N_PIX];
    logic [7:0]         kern [N_TAP];
    logic [7:0]         rd;
    logic [PIX_W-1:0]   pix_cnt;
    logic [PIX_W-1:0]   rd_addr;
    logic [CNT_W-1:0]   tap;
    logic [WIN_W-1:0]   win;
    logic [ACC_W-1:0]   acc;

    function automatic logic [ACC_W-1:0] match(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x;
        x = ~(a ^ b);
        match = '0;
        for (int i = 0; i < 8; i++) match += ACC_W'(x[i]);
    endfunction

    always_comb
        rd_addr = PIX_W'(((int'(win)/WIN_COLS)*STRIDE + int'(tap)/K)*IMG_W
                         + (int'(win)%WIN_COLS)*STRIDE + int'(tap)%K);

    // Image RAM is intentionally unreset; each frame overwrites it in full.
    always_ff @(posedge clk) begin
        if (pix_ready && pix_valid) ram[pix_cnt] <= pix_data;
        rd <= ram[rd_addr];
    end

`ifdef BNN_THRESH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) res_bit <= 1'b0;
        else if (state == COMPUTE && int'(tap) == N_TAP+1) res_bit <= acc >= ACC_W'(THRESH);
    end
`else
    assign res_bit = 1'b0;
`endif

    // Tap t is read at tap==t and accumulated at tap==t+1; tap==N_TAP+1 publishes the score.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            pix_ready  <= 1'b1;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_idx    <= '0;
            frame_done <= 1'b0;
            pix_cnt    <= '0;
            win        <= '0;
            tap        <= '0;
            acc        <= '0;
            for (int i = 0; i < N_TAP; i++) kern[i] <= KERNEL_INIT[8*(N_TAP-i)-1 -: 8];
        end else begin
            frame_done <= 1'b0;
            if (kw_valid && state != COMPUTE && int'(kw_addr) < N_TAP) kern[kw_addr] <= kw_data;
            case (state)
                LOAD: if (pix_valid) begin
                    pix_cnt <= int'(pix_cnt) == N_PIX-1 ? '0 : pix_cnt + 1'b1;
                    if (int'(pix_cnt) == N_PIX-1) begin
                        state     <= COMPUTE;
                        pix_ready <= 1'b0;
                        win       <= '0;
                        tap       <= '0;
                    end
                end
                COMPUTE: begin
                    tap <= tap + 1'b1;
                    if (tap == '0) acc <= '0;
                    else if (int'(tap) <= N_TAP) acc <= acc + match(rd, kern[KA_W'(tap - 1'b1)]);
                    if (int'(tap) == N_TAP+1) begin
                        state     <= EMIT;
                        res_valid <= 1'b1;
                        res_data  <= acc;
                        res_idx   <= win;
                    end
                end
                EMIT: if (res_ready) begin
                    res_valid <= 1'b0;
                    tap       <= '0;
                    win       <= int'(win) == N_WIN-1 ? '0 : win + 1'b1;
                    state     <= int'(win) == N_WIN-1 ? LOAD : COMPUTE;
                    if (int'(win) == N_WIN-1) begin
                        pix_ready  <= 1'b1;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_bnn_xnor_conv_engine.sv
// tb_bnn_xnor_conv_engine: directed frames with hand-computed window scores.
module tb_bnn_xnor_conv_engine;
`ifdef BNN_THRESH_EN
    localparam int THRESH = 40;
`else
    localparam int THRESH = 36;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_valid = 1'b0;
    logic       pix_ready;
    logic [7:0] pix_data = 8'h00;
    logic       kw_valid = 1'b0;
    logic [3:0] kw_addr = 4'd0;
    logic [7:0] kw_data = 8'h00;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [6:0] res_data;
    logic [3:0] res_idx;
    logic       res_bit;
    logic       frame_done;

    int checks = 0;
    int errors = 0;
    int since = 0;

    bnn_xnor_conv_engine #(.THRESH(THRESH)) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .kw_valid(kw_valid), .kw_addr(kw_addr), .kw_data(kw_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_idx(res_idx), .res_bit(res_bit), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        since++;
    endtask

    function automatic int exp_bit(input int score);
`ifdef BNN_THRESH_EN
        return score >= THRESH ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic send_image(input logic [7:0] v);
        check("pix_ready_idle", pix_ready, 1);
        pix_valid = 1'b1;
        pix_data  = v;
        for (int i = 0; i < 784; i++) step();
        pix_valid = 1'b0;
        since = 0;
    endtask

    task automatic collect(input int exp, input int first, input int n, input bit chk_lat);
        for (int k = first; k < first + n; k++) begin
            while (!res_valid && since < 60) step();
            if (k != first || chk_lat) check("latency", since, 11);
            check("res_data", res_data, exp);
            check("res_idx", res_idx, k);
            check("res_bit", res_bit, exp_bit(exp));
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
            since = 0;
            check("frame_done", frame_done, k == 8 ? 1 : 0);
            check("res_valid_drop", res_valid, 0);
            check("pix_ready", pix_ready, k == 8 ? 1 : 0);
        end
    endtask

    initial begin
        step();
        step();
        check("rst_pix_ready", pix_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_idx", res_idx, 0);
        check("rst_res_bit", res_bit, 0);
        check("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;
        step();

        // zero image, default kernel: 3+6+3 per row -> 36
        send_image(8'h00);
        collect(36, 0, 9, 1);

        // E3 image: 8+1+8 per row -> 51
        send_image(8'hE3);
        collect(51, 0, 9, 1);

        // backpressure at the first score; pixels offered meanwhile must be refused
        send_image(8'hE3);
        while (!res_valid && since < 60) step();
        check("bp_latency", since, 11);
        pix_valid = 1'b1;
        pix_data  = 8'h55;
        for (int i = 0; i < 20; i++) begin
            step();
            check("bp_valid", res_valid, 1);
            check("bp_data", res_data, 51);
            check("bp_idx", res_idx, 0);
            check("bp_pix_ready", pix_ready, 0);
        end
        pix_valid = 1'b0;
        collect(51, 0, 9, 0);

        // kernel writes during COMPUTE are ignored (else window 0 would score 46)
        send_image(8'hE3);
        step();
        step();
        kw_valid = 1'b1;
        kw_addr  = 4'd0;
        kw_data  = 8'h00;
        step();
        step();
        step();
        kw_valid = 1'b0;
        collect(51, 0, 3, 1);
        while (!res_valid && since < 60) step();
        check("pre_rst_valid", res_valid, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", res_valid, 0);
        check("async_rst_pix_ready", pix_ready, 1);
        check("async_rst_data", res_data, 0);
        step();
        rst_n = 1'b1;
        step();
        send_image(8'h00);
        collect(36, 0, 9, 1);

        // kernel all-FF written during the pixel stream, plus an out-of-range write
        pix_valid = 1'b1;
        pix_data  = 8'h01;
        for (int i = 0; i < 784; i++) begin
            kw_valid = i < 10;
            kw_addr  = i < 9 ? 4'(i) : 4'd9;
            kw_data  = i < 9 ? 8'hFF : 8'h00;
            step();
        end
        pix_valid = 1'b0;
        kw_valid  = 1'b0;
        since = 0;
        collect(9, 0, 9, 1);

        // reset restores the initial kernel
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        send_image(8'h00);
        collect(36, 0, 9, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
